// File: rtl/midi_pkg.sv
// Shared MIDI types and constants for the transmit path, the sequencer and benches.
package midi_pkg;

    localparam int MIDI_BAUD  = 31250;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] NOTE_OFF    = 8'h80;
    localparam logic [7:0] NOTE_ON     = 8'h90;
    localparam logic [7:0] CTRL_CHANGE = 8'hB0;

endpackage

// File: rtl/midi_uart_tx_if.sv
// Byte handshake between the MIDI message sequencer and the UART transmitter.
interface midi_uart_tx_if;

    // A byte transfers on a rising clk edge where tx_valid && tx_ready. The master
    // holds tx_data stable while tx_valid is high; tx_ready never depends on tx_valid.
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/midi_uart_tx_bit_timer.sv
// Down-counting bit-period timer: reload on load, one-cycle done pulse at zero.
module bit_timer #(
    parameter int CLKS_PER_BIT = 1600
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int              TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;
    logic          running;

    // Stops at zero unless reloaded, so an idle transmitter never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= RELOAD;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign done = running && (count == '0);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT serializer: 8N1 frames at BAUD_RATE, bytes taken over a valid/ready handshake.
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = MIDI_BAUD
) (
    input  logic            clk,
    input  logic            reset,
    midi_uart_tx_if.slave   tx,
    output logic            tx_out,
    output logic            busy,
    output tx_state_t       state_dbg
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_rate
            $error("midi_uart_tx: CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    tx_state_t  state, state_n;
    logic [7:0] shift, shift_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic       tx_out_n;
    logic       ready_q, ready_n;
    logic       busy_n;
    logic       timer_load;
    logic       bit_done;

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .done  (bit_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            tx_out  <= 1'b1;
            ready_q <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx_out  <= tx_out_n;
            ready_q <= ready_n;
            busy    <= busy_n;
        end
    end

    // Every output is registered, so each branch computes the next line level directly.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_idx_n  = bit_idx;
        tx_out_n   = tx_out;
        ready_n    = ready_q;
        busy_n     = busy;
        timer_load = 1'b0;
        case (state)
            IDLE: begin
                if (tx.tx_valid && ready_q) begin
                    shift_n    = tx.tx_data;
                    state_n    = START;
                    timer_load = 1'b1;
                    tx_out_n   = 1'b0;
                    ready_n    = 1'b0;
                    busy_n     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n    = DATA;
                    bit_idx_n  = 3'd0;
                    tx_out_n   = shift[0];
                    timer_load = 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    timer_load = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_n  = STOP;
                        tx_out_n = 1'b1;
                    end else begin
                        shift_n   = shift >> 1;
                        tx_out_n  = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_n = IDLE;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign tx.tx_ready = ready_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: a small-divider DUT with a frame monitor and a default-rate DUT with a synchronized receiver.
module tb_midi_uart_tx;
    import midi_pkg::*;

    localparam int CPB     = 4;
    localparam int CPB_BIG = 50_000_000 / 31250;
    localparam int FRAME   = 10 * CPB;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    midi_uart_tx_if bus ();
    midi_uart_tx_if bus_b ();

    logic      tx_out, busy, tx_out_b, busy_b;
    tx_state_t st, st_b;

    midi_uart_tx #(.CLK_FREQ_HZ(125_000), .BAUD_RATE(31250)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .tx        (bus),
        .tx_out    (tx_out),
        .busy      (busy),
        .state_dbg (st)
    );

    midi_uart_tx u_big (
        .clk       (clk),
        .reset     (reset),
        .tx        (bus_b),
        .tx_out    (tx_out_b),
        .busy      (busy_b),
        .state_dbg (st_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Call away from the rising edge; returns just after the accepting edge, acc = that cycle's index.
    task automatic send(input logic [7:0] b, input bit hold, output int acc);
        int t;
        t = 0;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("accept_timeout", bus.tx_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc - 1;
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    // Frame monitor: captures a whole frame from its falling edge and decodes mid-bit.
    initial begin : mon
        logic       prev;
        logic       smp[0:FRAME-1];
        logic [9:0] bits;
        bit         abort;
        int         glitches;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                prev = 1'b1;
            end else if (prev === 1'b1 && tx_out === 1'b0) begin
                abort  = 1'b0;
                smp[0] = tx_out;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (reset === 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    smp[k] = tx_out;
                end
                if (!abort) begin
                    glitches = 0;
                    for (int b = 0; b < 10; b++) begin
                        bits[b] = smp[b*CPB + CPB/2];
                        for (int j = 0; j < CPB; j++)
                            if (smp[b*CPB + j] !== bits[b]) glitches++;
                    end
                    check("frame_bit_width", glitches, 0);
                    check("frame_start_bit", bits[0], 0);
                    check("frame_stop_bit", bits[9], 1);
                    check("frame_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("frame_byte", bits[8:1], exp_q.pop_front());
                    prev = smp[FRAME-1];
                end else begin
                    prev = 1'b1;
                end
            end else begin
                prev = tx_out;
            end
        end
    end

    // Default-rate receiver: two-flop synchronizer then mid-bit sampling.
    logic s1 = 1'b1, s2 = 1'b1;
    always @(posedge clk) begin
        s1 <= tx_out_b;
        s2 <= s1;
    end

    initial begin : rx_big
        logic       prevb;
        logic [7:0] rb;
        prevb = 1'b1;
        forever begin
            @(negedge clk);
            if (prevb === 1'b1 && s2 === 1'b0) begin
                repeat (CPB_BIG/2) @(negedge clk);
                check("big_start_mid", s2, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB_BIG) @(negedge clk);
                    rb[i] = s2;
                end
                repeat (CPB_BIG) @(negedge clk);
                check("big_stop_mid", s2, 1);
                check("big_frame_expected", exp_b_q.size() > 0, 1);
                if (exp_b_q.size() > 0) check("big_frame_byte", rb, exp_b_q.pop_front());
                prevb = s2;
            end else begin
                prevb = s2;
            end
        end
    end

    logic rec_line[1:10*CPB_BIG+1];
    logic rec_busy[1:10*CPB_BIG+1];

    initial begin : stim
        int         a1, a2, a3, acc, t, cnt;
        logic [7:0] b;
        logic [9:0] fb;

        reset          = 1'b1;
        bus.tx_valid   = 1'b0;
        bus.tx_data    = 8'h00;
        bus_b.tx_valid = 1'b0;
        bus_b.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        check("reset_state", st, IDLE);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_tx_out", tx_out, 1);
            check("idle_tx_ready", bus.tx_ready, 1);
            check("idle_busy", busy, 0);
        end

        // Single byte, exact cycle-by-cycle line
        b = NOTE_ON;
        exp_q.push_back(b);
        send(b, 1'b0, acc);
        for (int c = 1; c <= FRAME; c++) begin
            wait_cyc(acc + c);
            if (c <= CPB)           check("single_start", tx_out, 0);
            else if (c <= 9 * CPB)  check("single_data", tx_out, b[(c - CPB - 1) / CPB]);
            else                    check("single_stop", tx_out, 1);
            check("single_busy_ready", bus.tx_ready, 0);
        end
        wait_cyc(acc + FRAME + 1);
        check("single_ready_back", bus.tx_ready, 1);
        check("single_busy_clear", busy, 0);
        repeat (5) @(negedge clk);

        // Back-to-back with tx_valid held
        exp_q.push_back(8'h90);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h64);
        send(8'h90, 1'b1, a1);
        send(8'h3C, 1'b1, a2);
        send(8'h64, 1'b0, a3);
        check("b2b_period_1", a2 - a1, FRAME + 1);
        check("b2b_period_2", a3 - a1, 2 * (FRAME + 1));
        wait_cyc(a1 + 122);
        check("b2b_last_stop_line", tx_out, 1);
        check("b2b_last_stop_ready", bus.tx_ready, 0);
        wait_cyc(a1 + 123);
        check("b2b_ready_after", bus.tx_ready, 1);
        repeat (5) @(negedge clk);

        // Handshake attempts and data changes mid-frame are ignored
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b0, acc);
        wait_cyc(acc + 10);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midframe_ready_low", bus.tx_ready, 0);
            check("midframe_busy", busy, 1);
        end
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        wait_cyc(acc + FRAME + 1);
        check("midframe_ready_back", bus.tx_ready, 1);
        wait_cyc(acc + FRAME + 5);
        check("midframe_no_extra_line", tx_out, 1);
        check("midframe_no_extra_ready", bus.tx_ready, 1);

        // Reset mid-frame, second cycle of data bit 3
        send(8'hA5, 1'b0, acc);
        wait_cyc(acc + 18);
        check("rst_pre_line", tx_out, 0);
        reset = 1'b1;
        #1;
        check("rst_async_line", tx_out, 1);
        check("rst_async_ready", bus.tx_ready, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_state", st, IDLE);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_ready", bus.tx_ready, 1);
        check("rst_release_line", tx_out, 1);
        exp_q.push_back(8'h01);
        send(8'h01, 1'b0, acc);
        wait_cyc(acc + FRAME + 5);

        // Default divider: bit durations and receiver decode
        exp_b_q.push_back(CTRL_CHANGE);
        bus_b.tx_data  = CTRL_CHANGE;
        bus_b.tx_valid = 1'b1;
        check("big_ready_before", bus_b.tx_ready, 1);
        @(posedge clk);
        #1;
        acc = cyc - 1;
        bus_b.tx_valid = 1'b0;
        for (int k = 1; k <= 10 * CPB_BIG + 1; k++) begin
            wait_cyc(acc + k);
            rec_line[k] = tx_out_b;
            rec_busy[k] = busy_b;
        end
        check("big_ready_after", bus_b.tx_ready, 1);
        fb = {1'b1, CTRL_CHANGE, 1'b0};
        for (int bi = 0; bi < 10; bi++) begin
            cnt = 0;
            for (int j = 0; j < CPB_BIG; j++)
                if (rec_line[1 + bi*CPB_BIG + j] === fb[bi]) cnt++;
            check("big_bit_len", cnt, CPB_BIG);
        end
        cnt = 0;
        for (int k = 1; k <= 10 * CPB_BIG + 1; k++)
            if (rec_busy[k] === 1'b1) cnt++;
        check("big_frame_len", cnt, 10 * CPB_BIG);
        check("big_busy_end", rec_busy[10*CPB_BIG+1], 0);
        check("big_line_end", rec_line[10*CPB_BIG+1], 1);

        t = 0;
        while ((exp_q.size() != 0 || exp_b_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        check("big_scoreboard_drained", exp_b_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
